axis_deltasigma_ctrl: RTL
=========================

// Module: axis_deltasigma_ctrl
// PURPOSE
//  Burst sequencer for the delta-sigma input path. Generates the modulator clock, waits for
//  lock (clk_detect) plus a settle period, then gates the input block's enable for exactly
//  burst_len accepted AXIS beats. Monitors the input block's AXIS handshake; reports done/error.
// PARAMETERS
//  CNT_W          16    width of burst_len / sample_count
//  DIV_W          8     width of clk_div (ds_clk half-period in aclk cycles)
//  SETTLE_EDGES   64    ds_clk_o rising edges discarded after lock before capture
//  LOCK_TIMEOUT   4096  aclk cycles allowed in SETTLE for clk_detect to assert
//  STALL_LIMIT    1024  aclk cycles of tvalid&~tready tolerated (DSCTRL_STALL_EN only)
// PORTS
//  aclk          in   1      clock
//  aresetn       in   1      reset, synchronous, active-low
//  start         in   1      1-cycle pulse; latches burst_len, clk_div; begins sequence
//  abort         in   1      return to IDLE from any state
//  burst_len     in   CNT_W  samples per burst
//  clk_div       in   DIV_W  ds_clk_o half-period; 0 treated as 1
//  clk_detect    in   1      lock indication from input block
//  mon_tvalid    in   1      tap of input block m_axis_tvalid
//  mon_tready    in   1      tap of downstream m_axis_tready
//  ds_clk_o      out  1      generated modulator clock
//  ds_enable     out  1      to input block enable
//  busy          out  1      high in any state except IDLE
//  done          out  1      1-cycle pulse on burst completion
//  error         out  1      sticky; cleared by next accepted start
//  err_code      out  2      01 lock timeout, 10 clock lost, 11 stall; 00 when no error
//  sample_count  out  CNT_W  beats accepted in current/last burst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  Divider: when RUN (SETTLE/CAPTURE/FLUSH) ds_clk_o toggles every max(clk_div,1) aclk; on
//   leaving RUN it is forced low next cycle, divider counter cleared. First edge is rising.
//  Beat = mon_tvalid & mon_tready, sampled on aclk.
//  IDLE: start & ~abort & burst_len!=0 -> SETTLE, error/err_code/sample_count cleared.
//   start with burst_len==0 -> stay IDLE, done pulses next cycle, error cleared.
//  SETTLE: clock running, ds_enable=0. Timeout counter runs until clk_detect=1; reaching
//   LOCK_TIMEOUT -> ERROR(01). After clk_detect, count SETTLE_EDGES rising edges -> CAPTURE.
//   clk_detect dropping after lock restarts lock wait (timeout counter reset).
//  CAPTURE: ds_enable=1 (registered, asserted cycle after entry). Each beat increments
//   sample_count; beat making sample_count==burst_len -> FLUSH, ds_enable=0 next cycle.
//   clk_detect=0 -> ERROR(10).
//  FLUSH: ds_enable=0; beats not counted; wait first cycle with mon_tvalid=0 -> DONE.
//  DONE: done=1 one cycle -> IDLE.
//  ERROR: error=1, ds_enable=0, clock stopped; -> IDLE next cycle (error stays sticky).
//  abort: highest priority in every state incl. same-cycle start; -> IDLE, ds_enable=0,
//   no done, error unchanged. start while busy ignored.
//  sample_count saturates at burst_len; wraps never.
// CONFIGURATION
//  DSCTRL_STALL_EN defined: in CAPTURE, counter of consecutive mon_tvalid&~mon_tready
//   cycles; reaching STALL_LIMIT -> ERROR(11). Counter clears on any cycle without stall.
//  Not defined: no stall counter; err_code 11 never produced; STALL_LIMIT unused.
// TESTING
//  clk_div=2, burst_len=8, clk_detect high after 20 cycles, tready=1 -> 8 beats counted,
//   done one pulse, sample_count=8, ds_clk_o period 4 aclk, ds_enable low after 8th beat.
//  clk_detect held 0 -> error=1, err_code=01 after LOCK_TIMEOUT cycles in SETTLE, ds_clk_o low.
//  Drop clk_detect after 3 beats -> err_code=10, sample_count=3, no done; next start clears.
//  abort coincident with start in IDLE, then abort mid-CAPTURE -> IDLE, no done, busy=0.
//  burst_len=0 start -> done pulse next cycle, ds_clk_o never toggles.
//  DSCTRL_STALL_EN, tready=0 during CAPTURE -> err_code=11 after STALL_LIMIT; without macro
//   same stimulus stays in CAPTURE indefinitely.

Source files
------------

// File: rtl/axis_deltasigma_ctrl.sv
// -----------------------------------------------------------------------------
// axis_deltasigma_ctrl
//   Burst sequencer for the delta-sigma input path. Runs the modulator clock,
//   waits for the input block to report lock plus a settle period, then enables
//   the input block for exactly burst_len accepted AXIS beats while watching the
//   tapped handshake. Reports completion (done) or a sticky error (error/err_code).
//
//   Optional feature macro: DSCTRL_STALL_EN
//     defined   -> CAPTURE aborts with err_code 11 after STALL_LIMIT consecutive
//                  cycles of mon_tvalid & ~mon_tready.
//     undefined -> no stall supervision; STALL_LIMIT is unused.
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   start, abort         burst request pulse; return-to-idle (highest priority)
//   burst_len, clk_div   latched on an accepted start
//   clk_detect           lock indication from the input block
//   mon_tvalid/tready    tap of the input block AXIS output handshake
//   ds_clk_o, ds_enable  modulator clock and input block enable
//   busy, done, error    status; err_code 01 lock timeout, 10 clock lost, 11 stall
//   sample_count         beats accepted in the current/last burst
// -----------------------------------------------------------------------------
module axis_deltasigma_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DIV_W        = 8,
  parameter int SETTLE_EDGES = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STALL_LIMIT  = 1024
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             clk_detect,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  output logic             ds_clk_o,
  output logic             ds_enable,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] sample_count
);

  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SE_W = $clog2(SETTLE_EDGES + 1);

  localparam logic [1:0] ERR_LOCK = 2'b01;
  localparam logic [1:0] ERR_CLK  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CAPTURE, S_FLUSH, S_DONE, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, clk_div_q, clk_div_d, div_eff;
  logic [CNT_W-1:0] burst_len_q, burst_len_d, sample_count_q, sample_count_d, cnt_inc;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [SE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic             ds_clk_q, ds_clk_d, ds_enable_q, ds_enable_d;
  logic             done_q, done_d, error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             beat, tick, rise, run_keep;

`ifdef DSCTRL_STALL_EN
  localparam int         ST_W      = $clog2(STALL_LIMIT + 1);
  localparam logic [1:0] ERR_STALL = 2'b11;
  logic [ST_W-1:0] stall_q, stall_d;
`else
  logic unused_stall_limit;
  assign unused_stall_limit = (STALL_LIMIT != 0);
`endif

  function automatic logic in_run(input state_e s);
    return s inside {S_SETTLE, S_CAPTURE, S_FLUSH};
  endfunction

  assign beat    = mon_tvalid & mon_tready;
  assign cnt_inc = sample_count_q + CNT_W'(1);
  assign div_eff = (clk_div_q == '0) ? DIV_W'(1) : clk_div_q;
  assign tick    = (div_cnt_q == div_eff - DIV_W'(1));
  // A rising modulator edge is produced at the end of this cycle.
  assign rise    = in_run(state_q) && tick && !ds_clk_q;

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    burst_len_d    = burst_len_q;
    clk_div_d      = clk_div_q;
    timeout_d      = timeout_q;
    edge_cnt_d     = edge_cnt_q;
    sample_count_d = sample_count_q;
    error_d        = error_q;
    err_code_d     = err_code_q;
    done_d         = 1'b0;
`ifdef DSCTRL_STALL_EN
    stall_d        = '0;
`endif

    if (abort) begin
      // Abort beats everything, including a same-cycle start; status is kept.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            error_d    = 1'b0;
            err_code_d = 2'b00;
            if (burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d        = S_SETTLE;
              burst_len_d    = burst_len;
              clk_div_d      = clk_div;
              sample_count_d = '0;
              timeout_d      = '0;
              edge_cnt_d     = '0;
            end
          end
        end
        S_SETTLE: begin
          if (!clk_detect) begin
            // Lost or not yet locked: settle edges restart from zero.
            edge_cnt_d = '0;
            if (timeout_q == TO_W'(LOCK_TIMEOUT - 1)) begin
              state_d    = S_ERROR;
              error_d    = 1'b1;
              err_code_d = ERR_LOCK;
            end else begin
              timeout_d = timeout_q + TO_W'(1);
            end
          end else begin
            timeout_d = '0;
            if (rise) begin
              if (edge_cnt_q == SE_W'(SETTLE_EDGES - 1)) state_d = S_CAPTURE;
              else edge_cnt_d = edge_cnt_q + SE_W'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (!clk_detect) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_CLK;
          end else begin
            if (beat && (sample_count_q != burst_len_q)) begin
              sample_count_d = cnt_inc;
              if (cnt_inc == burst_len_q) state_d = S_FLUSH;
            end
`ifdef DSCTRL_STALL_EN
            if (mon_tvalid && !mon_tready) begin
              if (stall_q == ST_W'(STALL_LIMIT - 1)) begin
                state_d    = S_ERROR;
                error_d    = 1'b1;
                err_code_d = ERR_STALL;
              end else begin
                stall_d = stall_q + ST_W'(1);
              end
            end
`endif
          end
        end
        S_FLUSH: begin
          if (!mon_tvalid) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Modulator clock divider and registered enable
  // ---------------------------------------------------------------------------
  always_comb begin
    // Run only while staying inside SETTLE/CAPTURE/FLUSH, so the clock is
    // forced low on the very edge that leaves the running states.
    run_keep  = in_run(state_q) && in_run(state_d);
    div_cnt_d = '0;
    ds_clk_d  = 1'b0;
    if (run_keep) begin
      if (tick) begin
        div_cnt_d = '0;
        ds_clk_d  = ~ds_clk_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        ds_clk_d  = ds_clk_q;
      end
    end
    // High from the second CAPTURE cycle; drops on the edge that leaves CAPTURE.
    ds_enable_d = (state_q == S_CAPTURE) && (state_d == S_CAPTURE);
  end

  always_ff @(posedge aclk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (!aresetn) begin
      state_q        <= S_IDLE;
      div_cnt_q      <= '0;
      clk_div_q      <= '0;
      burst_len_q    <= '0;
      sample_count_q <= '0;
      timeout_q      <= '0;
      edge_cnt_q     <= '0;
      ds_clk_q       <= 1'b0;
      ds_enable_q    <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= 2'b00;
`ifdef DSCTRL_STALL_EN
      stall_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      clk_div_q      <= clk_div_d;
      burst_len_q    <= burst_len_d;
      sample_count_q <= sample_count_d;
      timeout_q      <= timeout_d;
      edge_cnt_q     <= edge_cnt_d;
      ds_clk_q       <= ds_clk_d;
      ds_enable_q    <= ds_enable_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
`ifdef DSCTRL_STALL_EN
      stall_q        <= stall_d;
`endif
    end
  end

  assign ds_clk_o     = ds_clk_q;
  assign ds_enable    = ds_enable_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign sample_count = sample_count_q;

endmodule
